// File: rtl/vend_controller.sv
// vend_controller
// Coin-operated vending controller. Accepts $1/$5/$10 coin button edges,
// tracks credit up to MAX_CREDIT, validates one-hot item selection on a buy
// edge, dispenses for one cycle (VEND), then presents change for one cycle
// (CHANGE) before returning to IDLE with credit cleared.
//
// Optional feature macro: AUTO_REFUND_EN
//   When defined, a counter refunds the full credit after TIMEOUT_CYCLES
//   consecutive CREDIT cycles without any coin or buy edge. When undefined,
//   credit is held indefinitely and no counter exists.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   one/five/ten in   coin buttons (level, edge-detected internally)
//   item_input   in   [3:0] item select, one-hot
//   buy_button   in   purchase request (level, edge-detected internally)
//   credit       out  [7:0] current credit
//   vend_item    out  [3:0] one-hot dispense strobe (VEND state only)
//   change_out   out  [7:0] change amount, zero unless change_valid
//   change_valid out  change strobe (CHANGE state only)
//   coin_reject  out  one-cycle strobe for a refused coin sum
//   sel_error    out  one-cycle strobe for a non-one-hot selection at buy
//   insufficient out  one-cycle strobe for credit below price at buy
module vend_controller #(
  parameter int PRICE0         = 1,
  parameter int PRICE1         = 5,
  parameter int PRICE2         = 10,
  parameter int PRICE3         = 15,
  parameter int MAX_CREDIT     = 99,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one,
  input  logic       five,
  input  logic       ten,
  input  logic [3:0] item_input,
  input  logic       buy_button,
  output logic [7:0] credit,
  output logic [3:0] vend_item,
  output logic [7:0] change_out,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       sel_error,
  output logic       insufficient
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t     state, state_nxt;
  logic [7:0] credit_nxt;
  logic [3:0] item_q, item_nxt;
  logic [7:0] price_q, price_nxt;
  logic       prev_one, prev_five, prev_ten, prev_buy;
  logic       one_edge, five_edge, ten_edge, buy_edge;
  logic [4:0] coin_sum;
  logic [8:0] credit_sum;
  logic       sel_onehot;
  logic [7:0] sel_price;
  logic [7:0] credit_eff;
  logic       coin_reject_nxt, sel_error_nxt, insufficient_nxt;

`ifdef AUTO_REFUND_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt, idle_cnt_nxt;
`endif

  assign one_edge  = one & ~prev_one;
  assign five_edge = five & ~prev_five;
  assign ten_edge  = ten & ~prev_ten;
  assign buy_edge  = buy_button & ~prev_buy;

  // Coins landing on the same edge are summed and accepted or refused together.
  assign coin_sum   = {4'd0, one_edge} + (five_edge ? 5'd5 : 5'd0) + (ten_edge ? 5'd10 : 5'd0);
  assign credit_sum = {1'b0, credit} + {4'd0, coin_sum};

  assign sel_onehot = (item_input != 4'd0) && ((item_input & (item_input - 4'd1)) == 4'd0);

  always_comb begin
    sel_price = 8'd0;
    case (item_input)
      4'b0001: sel_price = 8'(PRICE0);
      4'b0010: sel_price = 8'(PRICE1);
      4'b0100: sel_price = 8'(PRICE2);
      4'b1000: sel_price = 8'(PRICE3);
      default: sel_price = 8'd0;
    endcase
  end

  // Next-state logic. In IDLE/CREDIT the coin is applied first so a buy on
  // the same edge is judged against the updated credit (credit_eff).
  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    item_nxt         = item_q;
    price_nxt        = price_q;
    credit_eff       = credit;
    coin_reject_nxt  = 1'b0;
    sel_error_nxt    = 1'b0;
    insufficient_nxt = 1'b0;
`ifdef AUTO_REFUND_EN
    idle_cnt_nxt     = '0;
`endif
    case (state)
      IDLE, CREDIT: begin
        if (coin_sum != 5'd0) begin
          if (credit_sum > 9'(MAX_CREDIT)) coin_reject_nxt = 1'b1;
          else                             credit_eff      = credit_sum[7:0];
        end
        credit_nxt = credit_eff;
        state_nxt  = (credit_eff != 8'd0) ? CREDIT : IDLE;
        if (buy_edge) begin
          if (!sel_onehot) begin
            sel_error_nxt = 1'b1;
          end else if (credit_eff < sel_price) begin
            insufficient_nxt = 1'b1;
          end else begin
            item_nxt  = item_input;
            price_nxt = sel_price;
            state_nxt = VEND;
          end
        end
`ifdef AUTO_REFUND_EN
        // Refund with a zero price so the whole credit comes back as change.
        if (state == CREDIT && coin_sum == 5'd0 && !buy_edge) begin
          if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = CHANGE;
            price_nxt = 8'd0;
          end else begin
            idle_cnt_nxt = idle_cnt + TW'(1);
          end
        end
`endif
      end
      VEND: begin
        if (coin_sum != 5'd0) coin_reject_nxt = 1'b1;
        state_nxt = CHANGE;
      end
      CHANGE: begin
        if (coin_sum != 5'd0) coin_reject_nxt = 1'b1;
        credit_nxt = 8'd0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge-detect registers reset high so buttons held across reset release
  // do not register as a fresh press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      credit       <= 8'd0;
      item_q       <= 4'd0;
      price_q      <= 8'd0;
      prev_one     <= 1'b1;
      prev_five    <= 1'b1;
      prev_ten     <= 1'b1;
      prev_buy     <= 1'b1;
      coin_reject  <= 1'b0;
      sel_error    <= 1'b0;
      insufficient <= 1'b0;
`ifdef AUTO_REFUND_EN
      idle_cnt     <= '0;
`endif
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      item_q       <= item_nxt;
      price_q      <= price_nxt;
      prev_one     <= one;
      prev_five    <= five;
      prev_ten     <= ten;
      prev_buy     <= buy_button;
      coin_reject  <= coin_reject_nxt;
      sel_error    <= sel_error_nxt;
      insufficient <= insufficient_nxt;
`ifdef AUTO_REFUND_EN
      idle_cnt     <= idle_cnt_nxt;
`endif
    end
  end

  assign vend_item    = (state == VEND) ? item_q : 4'd0;
  assign change_valid = (state == CHANGE);
  assign change_out   = change_valid ? (credit - price_q) : 8'd0;

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller
// Directed scoreboard bench for vend_controller. Each step pushes the
// expected outputs, drives the inputs, advances one clock and then pops
// the expectations and compares them against the DUT outputs.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       one, five, ten, buy_button;
  logic [3:0] item_input;
  logic [7:0] credit, change_out;
  logic [3:0] vend_item;
  logic       change_valid, coin_reject, sel_error, insufficient;

  typedef struct {
    string      tag;
    logic [7:0] value;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  vend_controller #(
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .one          (one),
    .five         (five),
    .ten          (ten),
    .item_input   (item_input),
    .buy_button   (buy_button),
    .credit       (credit),
    .vend_item    (vend_item),
    .change_out   (change_out),
    .change_valid (change_valid),
    .coin_reject  (coin_reject),
    .sel_error    (sel_error),
    .insufficient (insufficient)
  );

  always #5 clk = ~clk;

  task automatic push_exp(string tag, int value);
    exp_t e;
    e.tag   = tag;
    e.value = 8'(value);
    sb.push_back(e);
  endtask

  task automatic expect_outputs(int cr, int vend, int chg, int cv, int rej, int sel, int ins);
    push_exp("credit", cr);
    push_exp("vend_item", vend);
    push_exp("change_out", chg);
    push_exp("change_valid", cv);
    push_exp("coin_reject", rej);
    push_exp("sel_error", sel);
    push_exp("insufficient", ins);
  endtask

  // Drain the scoreboard, comparing each entry with the output it names.
  task automatic check_output();
    exp_t       e;
    logic [7:0] observed;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.tag)
        "credit":       observed = credit;
        "vend_item":    observed = {4'd0, vend_item};
        "change_out":   observed = change_out;
        "change_valid": observed = {7'd0, change_valid};
        "coin_reject":  observed = {7'd0, coin_reject};
        "sel_error":    observed = {7'd0, sel_error};
        "insufficient": observed = {7'd0, insufficient};
        default:        observed = 8'hxx;
      endcase
      checks++;
      assert (observed === e.value) else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic apply_stimulus(logic o, logic f, logic t, logic [3:0] item, logic buy);
    one        = o;
    five       = f;
    ten        = t;
    item_input = item;
    buy_button = buy;
    @(posedge clk);
    #1;
  endtask

  task automatic step(logic o, logic f, logic t, logic [3:0] item, logic buy,
                      int cr, int vend, int chg, int cv, int rej, int sel, int ins);
    expect_outputs(cr, vend, chg, cv, rej, sel, ins);
    apply_stimulus(o, f, t, item, buy);
    check_output();
  endtask

  initial begin
    reset      = 1'b0;
    one        = 1'b0;
    five       = 1'b0;
    ten        = 1'b0;
    buy_button = 1'b0;
    item_input = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] checking reset state");
    expect_outputs(0, 0, 0, 0, 0, 0, 0);
    check_output();
    reset = 1'b1;

    step(0, 0, 0, 4'd0, 0,   0, 0, 0, 0, 0, 0, 0);

    $display("[TB] coin pulses");
    step(1, 0, 0, 4'd0, 0,   1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,   1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 4'd0, 0,   6, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,   6, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4'd0, 0,  16, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,  16, 0, 0, 0, 0, 0, 0);

    $display("[TB] purchase item 2 with change");
    step(0, 0, 0, 4'b0100, 1,  16, 4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'b0100, 0,  16, 0, 6, 1, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,      0, 0, 0, 0, 0, 0, 0);

    $display("[TB] held coin counts once");
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 4'd0, 0,   1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,     1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 4'd0, 0,     6, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,     6, 0, 0, 0, 0, 0, 0);

    $display("[TB] insufficient credit and bad selection");
    step(0, 0, 0, 4'b1000, 1,  6, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 4'b1000, 0,  6, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'b0011, 1,  6, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 4'b0011, 0,  6, 0, 0, 0, 0, 0, 0);

    $display("[TB] approach credit ceiling");
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 4'd0, 0,  6 + 10 * i, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 4'd0, 0,  6 + 10 * i, 0, 0, 0, 0, 0, 0);
    end
    step(0, 1, 0, 4'd0, 0,  91, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,  91, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 4'd0, 0,  91 + i, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 4'd0, 0,  91 + i, 0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 1, 4'd0, 0,  95, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 4'd0, 0,  95, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 4'd0, 0,  96, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,  96, 0, 0, 0, 0, 0, 0);

    $display("[TB] purchase item 3, coin during vend is refused");
    step(0, 0, 0, 4'b1000, 1,  96, 8,  0, 0, 0, 0, 0);
    step(1, 0, 0, 4'b1000, 1,  96, 0, 81, 1, 1, 0, 0);
    step(0, 0, 0, 4'd0, 0,      0, 0,  0, 0, 0, 0, 0);

    $display("[TB] coin and buy on the same edge, then reset during vend");
    step(1, 0, 0, 4'b0001, 1,  1, 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    expect_outputs(0, 0, 0, 0, 0, 0, 0);
    check_output();
    @(posedge clk);
    #1;
    expect_outputs(0, 0, 0, 0, 0, 0, 0);
    check_output();
    reset = 1'b1;
    step(1, 0, 0, 4'b0001, 1,  0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,     0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,     0, 0, 0, 0, 0, 0, 0);

`ifdef AUTO_REFUND_EN
    $display("[TB] inactivity refund");
    step(0, 1, 0, 4'd0, 0,  5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,  5, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++)
      step(0, 0, 0, 4'd0, 0,  5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,  5, 0, 5, 1, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0,  0, 0, 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE0, 1, price of item 0 in dollars.
REQ-002 SHALL have parameter PRICE1, 5, price of item 1.
REQ-003 SHALL have parameter PRICE2, 10, price of item 2.
REQ-004 SHALL have parameter PRICE3, 15, price of item 3.
REQ-005 SHALL have parameter MAX_CREDIT, 99, credit ceiling in dollars.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, 1000, inactivity cycles before auto-refund.
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port one, input, 1, $1 coin button (level).
REQ-010 SHALL have port five, input, 1, $5 coin button (level).
REQ-011 SHALL have port ten, input, 1, $10 coin button (level).
REQ-012 SHALL have port item_input, input, 4, item select (one-hot, bit i = item i).
REQ-013 SHALL have port buy_button, input, 1, purchase request (level).
REQ-014 SHALL have port credit, output, 8, current credit in binary for the display driver.
REQ-015 SHALL have port vend_item, output, 4, one-hot dispense strobe.
REQ-016 SHALL have port change_out, output, 8, change/refund amount, valid with change_valid.
REQ-017 SHALL have port change_valid, output, 1, one-cycle change strobe.
REQ-018 SHALL have port coin_reject, output, 1, one-cycle strobe when a coin is refused.
REQ-019 SHALL have port sel_error, output, 1, one-cycle strobe for a non-one-hot selection at buy.
REQ-020 SHALL have port insufficient, output, 1, one-cycle strobe when credit is below price at buy.

Function
REQ-021 SHALL implement states IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
REQ-022 SHALL detect rising edges of one/five/ten/buy_button using registered previous values; a held level counts once.
REQ-023 SHALL add the sum of all coin edges sampled at edge k to credit at edge k; IDLE->CREDIT on any accepted coin.
REQ-024 SHALL reject the whole coin sum (credit unchanged, coin_reject=1 for one cycle) if credit+sum > MAX_CREDIT.
REQ-025 SHALL ignore coins sampled in VEND or CHANGE and pulse coin_reject for them.
REQ-026 SHALL, on a buy edge in IDLE/CREDIT with non-one-hot item_input, pulse sel_error; state unchanged.
REQ-027 SHALL, on a buy edge with one-hot item_input and credit < price, pulse insufficient; state unchanged.
REQ-028 SHALL, on a buy edge with one-hot item_input and credit >= price, latch the item and go to VEND at edge k.
REQ-029 SHALL drive vend_item = latched one-hot for exactly the cycle in VEND, then go to CHANGE.
REQ-030 SHALL, in CHANGE, drive change_out = credit - price and change_valid=1 for one cycle; next edge clears credit and goes to IDLE.
REQ-031 SHALL, when a coin edge and a buy edge share a cycle, apply the coin first and evaluate the buy against the updated credit.
REQ-032 SHALL hold change_out at 0 whenever change_valid=0.
REQ-033 SHALL ignore buy edges in VEND and CHANGE with no error strobes.

Reset
REQ-034 SHALL, while reset=0 (any state, mid-purchase included), force state IDLE, credit=0, vend_item=0, change_out=0, change_valid=0, coin_reject=0, sel_error=0, insufficient=0, timeout counter=0.
REQ-035 SHALL reset edge-detect registers to 1 so buttons held through reset release are not counted.

Configuration
REQ-036 SHALL, with AUTO_REFUND_EN defined, count cycles in CREDIT with no coin or buy edge and, at TIMEOUT_CYCLES, enter CHANGE with change_out=credit (price 0); any edge restarts the count.
REQ-037 SHALL, without AUTO_REFUND_EN, hold credit indefinitely with no timeout counter synthesized.

Verification
REQ-038 SHALL cover: one, five, ten pulsed in turn -> credit 1, 6, 16; one held 5 cycles -> credit +1 only.
REQ-039 SHALL cover: credit 16, item_input=4'b0100, buy -> vend_item=4'b0100 one cycle, then change_out=6 with change_valid, then credit=0 in IDLE.
REQ-040 SHALL cover: credit 6, item_input=4'b1000, buy -> insufficient pulse, credit stays 6; item_input=4'b0011, buy -> sel_error pulse.
REQ-041 SHALL cover: credit 95, ten edge -> coin_reject, credit stays 95; one edge -> credit 96.
REQ-042 SHALL cover: reset asserted during VEND -> all outputs 0 and IDLE immediately, no change_valid after release.
REQ-043 SHALL cover (AUTO_REFUND_EN, TIMEOUT_CYCLES=20): credit 5, idle 20 cycles -> change_out=5 with change_valid, credit 0.
